// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: per-stage payload layouts and their widths,
// plus a small helper used by the stage register to report occupancy.
package pipe_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic        branch;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] mem_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    typedef logic [1:0] occ_t;

    function automatic occ_t count_valid(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// One valid+data holding register with load, clear and optional
// zeroing of the payload whenever the entry is empty.
module pipe_skid_entry #(
    parameter int DATA_W      = 32,
    parameter bit ZERO_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // NOTE: reset is sampled on the clock edge, and all state uses <= so
    // every entry sees pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            if (ZERO_BUBBLE) r_data <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush and an
// optional skid entry so in_ready can come straight from a flop.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter bit SKID        = 1'b1,
    parameter bit ZERO_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              w_up;
    logic              w_down;
    logic              w_m_load;
    logic              w_m_clear;
    logic              w_s_load;
    logic              w_s_clear;
    logic [DATA_W-1:0] w_m_din;
    logic              w_s_valid;
    logic [DATA_W-1:0] w_s_data;

    assign w_up   = in_valid && in_ready;
    assign w_down = out_valid && out_ready;

    // NOTE: every output of this block gets a default first, so no path
    // through the if-chain can leave a latch behind.
    always_comb begin
        w_m_load  = 1'b0;
        w_m_clear = 1'b0;
        w_s_load  = 1'b0;
        w_s_clear = 1'b0;
        w_m_din   = in_data;
        if (flush) begin
            w_m_clear = 1'b1;
            w_s_clear = 1'b1;
        end else if (w_down && w_s_valid) begin
            // Skid refills main; upstream is blocked while skid is full.
            w_m_load  = 1'b1;
            w_m_din   = w_s_data;
            w_s_clear = 1'b1;
        end else if (w_up && (!out_valid || w_down)) begin
            w_m_load  = 1'b1;
        end else if (w_up) begin
            w_s_load  = 1'b1;
        end else if (w_down) begin
            w_m_clear = 1'b1;
        end
    end

    pipe_skid_entry #(
        .DATA_W      (DATA_W),
        .ZERO_BUBBLE (ZERO_BUBBLE)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_m_load),
        .i_clear (w_m_clear),
        .i_data  (w_m_din),
        .o_valid (out_valid),
        .o_data  (out_data)
    );

    generate
        if (SKID) begin : g_skid
            pipe_skid_entry #(
                .DATA_W      (DATA_W),
                .ZERO_BUBBLE (ZERO_BUBBLE)
            ) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_s_load),
                .i_clear (w_s_clear),
                .i_data  (in_data),
                .o_valid (w_s_valid),
                .o_data  (w_s_data)
            );
            assign in_ready = !w_s_valid;
        end else begin : g_single
            assign w_s_valid = 1'b0;
            assign w_s_data  = '0;
            assign in_ready  = !out_valid || out_ready;
        end
    endgenerate

    assign occupancy = count_valid(out_valid, w_s_valid);

endmodule
